// File: rtl/bp_update_scheduler.sv
// Branch predictor table-port scheduler: arbitrates fetch lookups and queued
// resolution updates onto one shared BTB/gskew port, and raises mispredict flushes.
`timescale 1ns/1ps
module bp_update_scheduler #(
  parameter int unsigned PC_W   = 32,
  parameter int unsigned QDEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            lookup_req,
  input  logic [PC_W-1:0] lookup_pc,
  output logic            lookup_ack,
  input  logic            resolve_valid,
  input  logic [PC_W-1:0] resolve_pc,
  input  logic            resolve_taken,
  input  logic            resolve_pred,
  output logic            tbl_en,
  output logic            tbl_we,
  output logic [PC_W-1:0] tbl_pc,
  output logic            tbl_taken,
  input  logic            btb_hit,
  input  logic            gskew_pred,
  output logic            pred_valid,
  output logic            pred_taken,
  output logic            mispredict,
  output logic            q_overflow
);

  localparam int unsigned PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(QDEPTH + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RD   = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
  localparam logic [1:0] WR   = 2'd3;

  logic [1:0]       state, next_state;
  logic [PC_W-1:0]  q_pc [QDEPTH];
  logic [QDEPTH-1:0] q_taken;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic [PC_W-1:0]  cap_pc;
  logic             squashed, rsp_pend;

  logic             ack_d, en_d, we_d, taken_d;
  logic [PC_W-1:0]  pc_d;

  logic q_full, do_pop, do_push, mp_now, in_flight;

  assign q_full    = (count == CNT_W'(QDEPTH));
  assign do_pop    = (state == WR) && (count != '0);
  assign do_push   = resolve_valid && (!q_full || do_pop);
  assign mp_now    = resolve_valid && (resolve_taken != resolve_pred);
  assign in_flight = (state == RD) || (state == RESP) || rsp_pend;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next state and next values of the registered port outputs
  always_comb begin
    next_state = state;
    ack_d      = 1'b0;
    en_d       = 1'b0;
    we_d       = 1'b0;
    pc_d       = '0;
    taken_d    = 1'b0;
    case (state)
      IDLE: begin
        if (lookup_req && !q_full) begin
          next_state = RD;
          ack_d      = 1'b1;
        end else if (count != '0) begin
          next_state = WR;
        end
      end
      RD: begin
        next_state = RESP;
        en_d       = 1'b1;
        pc_d       = cap_pc;
      end
      RESP: next_state = IDLE;
      WR: begin
        next_state = IDLE;
        en_d       = 1'b1;
        we_d       = 1'b1;
        pc_d       = q_pc[rd_ptr];
        taken_d    = q_taken[rd_ptr];
      end
      default: next_state = IDLE;
    endcase
  end

  // Registered outputs and lookup tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lookup_ack <= 1'b0;
      tbl_en     <= 1'b0;
      tbl_we     <= 1'b0;
      tbl_pc     <= '0;
      tbl_taken  <= 1'b0;
      pred_valid <= 1'b0;
      pred_taken <= 1'b0;
      mispredict <= 1'b0;
      q_overflow <= 1'b0;
      cap_pc     <= '0;
      squashed   <= 1'b0;
      rsp_pend   <= 1'b0;
    end else begin
      lookup_ack <= ack_d;
      tbl_en     <= en_d;
      tbl_we     <= we_d;
      tbl_pc     <= pc_d;
      tbl_taken  <= taken_d;
      mispredict <= mp_now;
      q_overflow <= resolve_valid && q_full && !do_pop;
      rsp_pend   <= (state == RESP);
      // Table data returns one cycle after the read, so sample while rsp_pend
      pred_valid <= rsp_pend && !squashed && !mp_now;
      pred_taken <= rsp_pend && !squashed && !mp_now && btb_hit && gskew_pred;
      if (ack_d) begin
        cap_pc   <= lookup_pc;
        squashed <= 1'b0;
      end else if (mp_now && in_flight) begin
        squashed <= 1'b1;
      end
    end
  end

  // Resolution-update FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // FIFO storage; contents are meaningless until written, so no reset
  always_ff @(posedge clk) begin
    if (do_push) begin
      q_pc[wr_ptr]    <= resolve_pc;
      q_taken[wr_ptr] <= resolve_taken;
    end
  end

endmodule

// File: tb/tb_bp_update_scheduler.sv
// Directed self-checking bench for bp_update_scheduler: lookup timing, hit
// gating, queue fill/overflow, mispredict squash, wrap-around and async reset.
`timescale 1ns/1ps
module tb_bp_update_scheduler;

  logic        clk;
  logic        rst_n;
  logic        lookup_req;
  logic [31:0] lookup_pc;
  logic        lookup_ack;
  logic        resolve_valid;
  logic [31:0] resolve_pc;
  logic        resolve_taken;
  logic        resolve_pred;
  logic        tbl_en;
  logic        tbl_we;
  logic [31:0] tbl_pc;
  logic        tbl_taken;
  logic        btb_hit;
  logic        gskew_pred;
  logic        pred_valid;
  logic        pred_taken;
  logic        mispredict;
  logic        q_overflow;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int ovf_cnt   = 0;
  logic [32:0] wlog[$];

  bp_update_scheduler #(.PC_W(32), .QDEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .lookup_req(lookup_req), .lookup_pc(lookup_pc), .lookup_ack(lookup_ack),
    .resolve_valid(resolve_valid), .resolve_pc(resolve_pc),
    .resolve_taken(resolve_taken), .resolve_pred(resolve_pred),
    .tbl_en(tbl_en), .tbl_we(tbl_we), .tbl_pc(tbl_pc), .tbl_taken(tbl_taken),
    .btb_hit(btb_hit), .gskew_pred(gskew_pred),
    .pred_valid(pred_valid), .pred_taken(pred_taken),
    .mispredict(mispredict), .q_overflow(q_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every table write and overflow pulse mid-cycle
  always @(negedge clk) begin
    if (tbl_en && tbl_we) wlog.push_back({tbl_pc, tbl_taken});
    if (q_overflow) ovf_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int base_log;
    int base_ovf;
    logic [31:0] epc;
    logic        etk;

    rst_n = 1'b0; lookup_req = 1'b0; lookup_pc = '0;
    resolve_valid = 1'b0; resolve_pc = '0; resolve_taken = 1'b0; resolve_pred = 1'b0;
    btb_hit = 1'b0; gskew_pred = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ack", 32'(lookup_ack), 32'd0);
    chk("rst_tbl_en", 32'(tbl_en), 32'd0);
    chk("rst_tbl_we", 32'(tbl_we), 32'd0);
    chk("rst_tbl_pc", tbl_pc, 32'd0);
    chk("rst_pred_valid", 32'(pred_valid), 32'd0);
    chk("rst_mispredict", 32'(mispredict), 32'd0);
    chk("rst_q_overflow", 32'(q_overflow), 32'd0);
    rst_n = 1'b1;
    step();

    // Idle lookup, hit and taken
    lookup_req = 1'b1; lookup_pc = 32'h100; btb_hit = 1'b1; gskew_pred = 1'b1;
    step(); chk("l1_ack", 32'(lookup_ack), 32'd1);
    lookup_req = 1'b0;
    step();
    chk("l1_rd_en", 32'(tbl_en), 32'd1);
    chk("l1_rd_we", 32'(tbl_we), 32'd0);
    chk("l1_rd_pc", tbl_pc, 32'h100);
    chk("l1_ack_pulse", 32'(lookup_ack), 32'd0);
    step(); chk("l1_pv_early", 32'(pred_valid), 32'd0);
    step();
    chk("l1_pv", 32'(pred_valid), 32'd1);
    chk("l1_pt", 32'(pred_taken), 32'd1);
    step(); chk("l1_pv_pulse", 32'(pred_valid), 32'd0);

    // Hit gating: no BTB hit means not taken
    lookup_req = 1'b1; lookup_pc = 32'h100; btb_hit = 1'b0; gskew_pred = 1'b1;
    step(); chk("l2_ack", 32'(lookup_ack), 32'd1);
    lookup_req = 1'b0;
    step(); step(); step();
    chk("l2_pv", 32'(pred_valid), 32'd1);
    chk("l2_pt", 32'(pred_taken), 32'd0);
    step();

    // Mispredict during RD squashes the lookup; update still written
    btb_hit = 1'b1;
    lookup_req = 1'b1; lookup_pc = 32'h300;
    step(); chk("m_ack", 32'(lookup_ack), 32'd1);
    lookup_req = 1'b0;
    resolve_valid = 1'b1; resolve_pc = 32'h200; resolve_taken = 1'b1; resolve_pred = 1'b0;
    step(); resolve_valid = 1'b0;
    chk("m_flush", 32'(mispredict), 32'd1);
    step(); chk("m_flush_pulse", 32'(mispredict), 32'd0);
    step(); chk("m_squash_pv", 32'(pred_valid), 32'd0);
    step();
    chk("m_wr_en", 32'(tbl_en), 32'd1);
    chk("m_wr_we", 32'(tbl_we), 32'd1);
    chk("m_wr_pc", tbl_pc, 32'h200);
    chk("m_wr_taken", 32'(tbl_taken), 32'd1);
    step();

    // Queue fill with lookups held: 4 queued, 5th dropped, WR forced when full
    base_log = wlog.size();
    base_ovf = ovf_cnt;
    lookup_req = 1'b1; lookup_pc = 32'h500;
    for (int i = 0; i < 5; i++) begin
      resolve_valid = 1'b1; resolve_pc = 32'h1000 + 32'(i * 4);
      resolve_taken = 1'(i & 1); resolve_pred = 1'(i & 1);
      step();
    end
    resolve_valid = 1'b0;
    chk("f_overflow", 32'(q_overflow), 32'd1);
    step(); chk("f_overflow_pulse", 32'(q_overflow), 32'd0);
    step(); step();
    chk("f_forced_we", 32'(tbl_we), 32'd1);
    chk("f_forced_pc", tbl_pc, 32'h1000);
    lookup_req = 1'b0;
    repeat (20) step();
    chk("f_nwrites", 32'(wlog.size() - base_log), 32'd4);
    chk("f_novf", 32'(ovf_cnt - base_ovf), 32'd1);
    for (int i = 0; i < 4; i++) begin
      if (base_log + i < wlog.size()) begin
        chk("f_order", wlog[base_log + i], {32'h1000 + 32'(i * 4), 1'(i & 1)});
      end
    end

    // Wrap-around: 10 updates, no lookups
    base_log = wlog.size();
    base_ovf = ovf_cnt;
    for (int i = 0; i < 10; i++) begin
      resolve_valid = 1'b1; resolve_pc = 32'h2000 + 32'(i * 16);
      resolve_taken = (i % 3 == 0); resolve_pred = (i % 3 == 0);
      step();
      resolve_valid = 1'b0;
      step();
    end
    repeat (10) step();
    chk("w_nwrites", 32'(wlog.size() - base_log), 32'd10);
    chk("w_novf", 32'(ovf_cnt - base_ovf), 32'd0);
    chk("w_idle_en", 32'(tbl_en), 32'd0);
    for (int i = 0; i < 10; i++) begin
      if (base_log + i < wlog.size()) begin
        epc = 32'h2000 + 32'(i * 16);
        etk = (i % 3 == 0);
        chk("w_order", wlog[base_log + i], {epc, etk});
      end
    end

    // Async reset while a write is on the port with entries still queued
    lookup_req = 1'b1; lookup_pc = 32'h400;
    for (int i = 0; i < 4; i++) begin
      resolve_valid = 1'b1; resolve_pc = 32'h3000 + 32'(i * 4);
      resolve_taken = 1'b1; resolve_pred = 1'b1;
      step();
      lookup_req = 1'b0;
    end
    resolve_valid = 1'b0;
    step();
    chk("r_wr_we", 32'(tbl_we), 32'd1);
    chk("r_wr_pc", tbl_pc, 32'h3000);
    #1 rst_n = 1'b0;
    #1;
    chk("r_async_en", 32'(tbl_en), 32'd0);
    chk("r_async_we", 32'(tbl_we), 32'd0);
    chk("r_async_pc", tbl_pc, 32'd0);
    base_log = wlog.size();
    step(); step();
    rst_n = 1'b1;
    repeat (6) step();
    chk("r_queue_empty", 32'(wlog.size() - base_log), 32'd0);
    lookup_req = 1'b1; lookup_pc = 32'h600; btb_hit = 1'b1; gskew_pred = 1'b1;
    step(); chk("r_ack", 32'(lookup_ack), 32'd1);
    lookup_req = 1'b0;
    step(); chk("r_rd_pc", tbl_pc, 32'h600);
    step(); step();
    chk("r_pv", 32'(pred_valid), 32'd1);
    chk("r_pt", 32'(pred_taken), 32'd1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/bp_update_scheduler.md
BP_UPDATE_SCHEDULER -- requirements
Module: bp_update_scheduler

Interface
REQ-001 Parameter: PC_W, 32, program-counter width.
REQ-002 Parameter: QDEPTH, 4, resolution-update queue depth (power of 2, >=2).
REQ-003 clk  input  1  sole clock; all state changes on posedge clk.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 lookup_req  input  1  fetch requests a prediction; held until lookup_ack.
REQ-006 lookup_pc  input  PC_W  PC to predict.
REQ-007 lookup_ack  output  1  one-cycle pulse: lookup accepted.
REQ-008 resolve_valid  input  1  one-cycle pulse: branch resolved in execute.
REQ-009 resolve_pc  input  PC_W  resolved branch PC.
REQ-010 resolve_taken  input  1  actual outcome.
REQ-011 resolve_pred  input  1  outcome that was predicted for this branch.
REQ-012 tbl_en  output  1  shared BTB/gskew table port enable.
REQ-013 tbl_we  output  1  1 = update write, 0 = read.
REQ-014 tbl_pc  output  PC_W  table port index PC.
REQ-015 tbl_taken  output  1  outcome written on update.
REQ-016 btb_hit  input  1  table read result, valid the cycle after a read.
REQ-017 gskew_pred  input  1  gskew direction, valid the cycle after a read.
REQ-018 pred_valid  output  1  one-cycle pulse: final prediction available.
REQ-019 pred_taken  output  1  btb_hit AND gskew_pred; qualified by pred_valid.
REQ-020 mispredict  output  1  one-cycle flush pulse.
REQ-021 q_overflow  output  1  one-cycle pulse: resolution update dropped.

Function
REQ-022 FSM states IDLE, RD, RESP, WR; all outputs registered.
REQ-023 IDLE, queue count < QDEPTH and lookup_req: pulse lookup_ack, capture lookup_pc, go RD.
REQ-024 IDLE, queue full, or queue non-empty with no lookup_req: go WR with queue head.
REQ-025 IDLE, queue empty, no lookup_req: stay IDLE, tbl_en=0.
REQ-026 RD: tbl_en=1, tbl_we=0, tbl_pc=captured PC; next state RESP.
REQ-027 RESP: sample btb_hit, gskew_pred; pred_valid=1, pred_taken=btb_hit&gskew_pred in the following cycle; next state IDLE.
REQ-028 Lookup latency: lookup_ack to pred_valid = 3 cycles.
REQ-029 WR: tbl_en=1, tbl_we=1, tbl_pc/tbl_taken=head entry; head popped at end of cycle; next state IDLE.
REQ-030 Queue: FIFO of {resolve_pc, resolve_taken}; push on every resolve_valid; wrap-around read/write pointers; count 0..QDEPTH.
REQ-031 Push and pop in the same cycle: both performed, count unchanged, including when full.
REQ-032 Push when full with no same-cycle pop: entry dropped, q_overflow=1 next cycle, queue contents unchanged.
REQ-033 mispredict=1 the cycle after resolve_valid with resolve_taken != resolve_pred, independent of queue state and of overflow.
REQ-034 Mispredict while in RD or RESP: the lookup is squashed; pred_valid stays 0; FSM still returns to IDLE on schedule.
REQ-035 Mispredict does not flush the queue; pending updates still drain.
REQ-036 tbl_en=0 in IDLE; tbl_we=0 whenever tbl_en=0.

Reset
REQ-037 rst_n low: state IDLE, queue empty, pointers/count 0; lookup_ack, tbl_en, tbl_we, tbl_taken, pred_valid, pred_taken, mispredict, q_overflow all 0; tbl_pc 0.
REQ-038 Reset mid-operation: outputs clear immediately (asynchronous); in-flight read or write abandoned; queued updates discarded.
REQ-039 First action no earlier than the first posedge clk after rst_n rises.

Verification
REQ-040 Idle lookup: lookup_req=1, lookup_pc=0x100, btb_hit=1, gskew_pred=1 -> lookup_ack at c1, RD read of 0x100 at c2, pred_valid=1, pred_taken=1 at c4.
REQ-041 Hit gating: same lookup with btb_hit=0, gskew_pred=1 -> pred_valid=1, pred_taken=0.
REQ-042 Queue fill: 5 back-to-back resolve_valid with lookup_req held high, QDEPTH=4 -> updates 1-4 queued, update 5 dropped with one q_overflow pulse, or accepted if its push coincides with a WR pop; WR forced once the queue is full, writes in FIFO order.
REQ-043 Mispredict squash: resolve_taken=1, resolve_pred=0 during RD -> mispredict pulse next cycle, no pred_valid for that lookup, update still written later.
REQ-044 Wrap-around: 10 updates with no lookups -> writes in exact push order with correct PCs/outcomes, count returns to 0.
REQ-045 Async reset in WR with 3 entries queued -> tbl_en drops without a clock edge, queue empty after release, next lookup served normally.
